// File: rtl/jtsdram_pkg.sv
// Shared definitions for the SDRAM tester: checker FSM states and the pattern
// LFSR, so the writer and the read-back checker generate identical sequences.
package jtsdram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    CMP,
    DONE
  } state_t;

  // Fibonacci taps on bits 15, 13, 12 and 10; feedback enters at bit 0
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam int          ERR_W     = 8;

  function automatic logic [15:0] lfsr_next(input logic [15:0] q);
    return {q[14:0], ^(q & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/jtsdram_lfsr.sv
// Pattern generator shared by the writer and the read-back checker.
// load restarts the sequence at SEED and takes priority over adv.
module jtsdram_lfsr
  import jtsdram_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        adv,
  output logic [15:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    q <= SEED;
    else if (load) q <= SEED;
    else if (adv)  q <= lfsr_next(q);
  end

endmodule

// File: rtl/jtsdram_rdcheck.sv
// Read-back checker: walks 0..LAST_ADDR, reads each word and compares it with
// the LFSR pattern, flagging mismatches and read timeouts.
module jtsdram_rdcheck
  import jtsdram_pkg::*;
#(
  parameter int              AW        = 22,
  parameter int              DW        = 16,
  parameter logic [15:0]     SEED      = LFSR_SEED,
  parameter logic [AW-1:0]   LAST_ADDR = {AW{1'b1}},
  parameter int              TMO       = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clr,
  output logic [AW-1:0]    addr,
  output logic             rd,
  input  logic             ack,
  input  logic             rdy,
  input  logic [DW-1:0]    din,
  output logic             bad,
  output logic             busy,
  output logic             done,
  output logic [ERR_W-1:0] err_cnt,
  output logic [AW-1:0]    first_err_addr
);

  // Handshake: rd stays high with addr stable until the cycle ack is seen;
  // rdy marks din valid for exactly one cycle and only counts after ack.
  localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

  state_t        state, state_nx;
  logic [7:0]    tmo_cnt;
  logic [DW-1:0] data_q;
  logic          skip_q;
  logic [15:0]   lfsr_q;
  logic [DW-1:0] expected;
  logic          load, adv, capture, timeout, mismatch, err_now;

  jtsdram_lfsr #(.SEED(SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .adv   (adv),
    .q     (lfsr_q)
  );

  assign expected = DW'(lfsr_q);

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    capture  = 1'b0;
    timeout  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nx = REQ;
          load     = 1'b1;
        end
      end
      REQ: begin
        if (ack) begin
          capture  = rdy;
          state_nx = rdy ? CMP : WAIT;
        end
      end
      WAIT: begin
        if (rdy) begin
          capture  = 1'b1;
          state_nx = CMP;
        end else if (tmo_cnt == TMO_LAST) begin
          timeout  = 1'b1;
          state_nx = CMP;
        end
      end
      CMP:     state_nx = (addr == LAST_ADDR) ? DONE : REQ;
      default: state_nx = IDLE;
    endcase
  end

  assign adv      = (state == CMP);
  assign mismatch = (state == CMP) && !skip_q && (data_q != expected);
  assign err_now  = mismatch || timeout;

  assign rd   = (state == REQ);
  assign busy = (state == REQ) || (state == WAIT) || (state == CMP);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr    <= '0;
      tmo_cnt <= '0;
      data_q  <= '0;
      skip_q  <= 1'b0;
    end else begin
      if (load)
        addr <= '0;
      else if (state == CMP && addr != LAST_ADDR)
        addr <= addr + AW'(1);
      if (state == REQ && ack)
        tmo_cnt <= '0;
      else if (state == WAIT)
        tmo_cnt <= tmo_cnt + 8'd1;
      // a timed-out read reaches CMP with nothing worth comparing
      if (capture) begin
        data_q <= din;
        skip_q <= 1'b0;
      end else if (timeout) begin
        skip_q <= 1'b1;
      end
    end
  end

  // An error in the same cycle as clr restarts the record from this error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bad            <= 1'b0;
      err_cnt        <= '0;
      first_err_addr <= '0;
    end else if (err_now) begin
      bad <= 1'b1;
      if (clr || err_cnt == '0)
        first_err_addr <= addr;
      if (clr)
        err_cnt <= ERR_W'(1);
      else if (err_cnt != '1)
        err_cnt <= err_cnt + ERR_W'(1);
    end else if (clr) begin
      bad            <= 1'b0;
      err_cnt        <= '0;
      first_err_addr <= '0;
    end
  end

endmodule

// File: tb/tb_jtsdram_rdcheck.sv
// Bench for jtsdram_rdcheck: a scripted SDRAM responder drives reads while a
// negedge monitor checks addresses, error status and latency against a model.
module tb_jtsdram_rdcheck;

  localparam int            AW   = 22;
  localparam int            DW   = 16;
  localparam int            NW   = 8;
  localparam logic [AW-1:0] LAST = AW'(NW - 1);
  localparam int            ST_W = 1 + 8 + AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          clr = 1'b0;
  logic          ack = 1'b0;
  logic          rdy = 1'b0;
  logic [DW-1:0] din = '0;
  logic [AW-1:0] addr, first_err_addr;
  logic          rd, bad, busy, done;
  logic [7:0]    err_cnt;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [AW-1:0]   exp_addr_q[$];
  logic [ST_W-1:0] exp_q[$];

  // reference model state
  logic          m_bad = 1'b0;
  int            m_cnt = 0;
  logic [AW-1:0] m_first = '0;

  // per-word plan: kind 0 good / 1 corrupt / 2 no rdy; clr 0 none / 1 before ack / 2 with compare
  int            p_kind[NW], p_same[NW], p_ack[NW], p_rdy[NW], p_clr[NW], p_start[NW];
  logic [DW-1:0] p_mask[NW];

  logic mon_en = 1'b0;
  logic in_pass = 1'b0;

  jtsdram_rdcheck #(.AW(AW), .DW(DW), .LAST_ADDR(LAST)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .clr            (clr),
    .addr           (addr),
    .rd             (rd),
    .ack            (ack),
    .rdy            (rdy),
    .din            (din),
    .bad            (bad),
    .busy           (busy),
    .done           (done),
    .err_cnt        (err_cnt),
    .first_err_addr (first_err_addr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int lfsr_step(input int q);
    int fb;
    fb = ((q >> 15) ^ (q >> 13) ^ (q >> 12) ^ (q >> 10)) & 1;
    return ((q << 1) | fb) & 32'hFFFF;
  endfunction

  task automatic model_clear();
    m_bad   = 1'b0;
    m_cnt   = 0;
    m_first = '0;
  endtask

  task automatic model_word(input bit err, input bit clr_now, input logic [AW-1:0] a);
    if (err && clr_now) begin
      m_bad   = 1'b1;
      m_cnt   = 1;
      m_first = a;
    end else if (clr_now) begin
      model_clear();
    end else if (err) begin
      m_bad = 1'b1;
      if (m_cnt == 0) m_first = a;
      if (m_cnt < 255) m_cnt++;
    end
    exp_q.push_back({m_bad, 8'(m_cnt), m_first});
  endtask

  task automatic clear_plan();
    for (int i = 0; i < NW; i++) begin
      p_kind[i] = 0;  p_same[i] = 0;  p_ack[i] = 2;  p_rdy[i] = 3;
      p_clr[i]  = 0;  p_start[i] = 0; p_mask[i] = 16'h0001;
    end
  endtask

  task automatic rand_plan(input bit all_bad);
    int r;
    for (int i = 0; i < NW; i++) begin
      p_ack[i]   = $urandom_range(0, 3);
      p_rdy[i]   = $urandom_range(1, 4);
      p_same[i]  = $urandom_range(0, 1);
      p_mask[i]  = DW'($urandom_range(1, 65535));
      p_start[i] = ($urandom_range(0, 7) == 0) ? 1 : 0;
      p_clr[i]   = 0;
      if (all_bad) begin
        p_kind[i] = 1;
      end else begin
        r = $urandom_range(0, 9);
        p_kind[i] = (r < 6) ? 0 : (r < 9) ? 1 : 2;
        r = $urandom_range(0, 9);
        if (r == 8) p_clr[i] = 1;
        if (r == 9 && p_kind[i] != 2) p_clr[i] = 2;
      end
    end
  endtask

  task automatic wait_rd(input int lim, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < lim; k++) begin
      if (rd) begin
        ok = 1'b1;
        return;
      end
      step();
    end
    fail_now("rd_wait_timeout");
  endtask

  task automatic run_pass();
    bit            ok;
    int            q;
    logic [DW-1:0] w;
    exp_addr_q.delete();
    exp_q.delete();
    for (int i = 0; i < NW; i++) exp_addr_q.push_back(AW'(i));
    q = 'hACE1;
    in_pass = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < NW; i++) begin
      w = DW'(q);
      q = lfsr_step(q);
      wait_rd(400, ok);
      if (!ok) break;
      if (p_start[i] != 0) start = 1'b1;
      if (p_clr[i] == 1) begin
        clr = 1'b1;
        model_clear();
      end
      if (p_start[i] != 0 || p_clr[i] == 1) begin
        step();
        start = 1'b0;
        clr   = 1'b0;
      end
      repeat (p_ack[i]) step();
      ack = 1'b1;
      if (p_kind[i] == 1) w = w ^ p_mask[i];
      if (p_kind[i] != 2 && p_same[i] != 0) begin
        rdy = 1'b1;
        din = w;
      end
      model_word(p_kind[i] != 0, p_clr[i] == 2, AW'(i));
      step();
      ack = 1'b0;
      rdy = 1'b0;
      if (p_kind[i] != 2) begin
        if (p_same[i] == 0) begin
          repeat (p_rdy[i] - 1) step();
          rdy = 1'b1;
          din = w;
          step();
          rdy = 1'b0;
        end
        if (p_clr[i] == 2) begin
          clr = 1'b1;
          step();
          clr = 1'b0;
        end
      end
    end
    for (int k = 0; k < 400 && !done; k++) step();
    check("done_at_end", done, 1);
    check("busy_at_end", busy, 0);
    check("rd_at_end", rd, 0);
    step();
    check("handshakes_left", exp_addr_q.size(), 0);
    check("words_unchecked", exp_q.size(), 0);
    check("end_bad", bad, m_bad);
    check("end_err_cnt", err_cnt, m_cnt);
    check("end_first_err_addr", first_err_addr, m_first);
    in_pass = 1'b0;
  endtask

  // monitor: pops the address queue at each handshake and the status queue
  // when the DUT next raises rd or done after finishing a word
  initial begin
    logic [ST_W-1:0] st;
    logic pending, got_rdy, rd_prev, done_prev;
    int   ack_cyc, rdy_cyc;
    pending = 1'b0; got_rdy = 1'b0; rd_prev = 1'b0; done_prev = 1'b0;
    ack_cyc = 0; rdy_cyc = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (pending && ((rd && !rd_prev) || (done && !done_prev))) begin
          if (exp_q.size() == 0) begin
            fail_now("status_queue_empty");
          end else begin
            st = exp_q.pop_front();
            check("bad", bad, st[ST_W-1]);
            check("err_cnt", err_cnt, st[AW +: 8]);
            check("first_err_addr", first_err_addr, st[AW-1:0]);
          end
          if (got_rdy) check("rdy_to_next_rd", cyc - rdy_cyc, 2);
          else check("timeout_length", (cyc - ack_cyc >= 256) && (cyc - ack_cyc <= 258), 1);
          pending = 1'b0;
        end
        if (rd && ack) begin
          if (exp_addr_q.size() == 0) fail_now("unexpected_handshake");
          else check("rd_addr", addr, exp_addr_q.pop_front());
          pending = 1'b1;
          got_rdy = 1'b0;
          ack_cyc = cyc;
        end
        if (pending && rdy && !got_rdy) begin
          got_rdy = 1'b1;
          rdy_cyc = cyc;
        end
        if (clr && in_pass) check("busy_during_clr", busy, 1);
      end
      rd_prev   = rd;
      done_prev = done;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    repeat (3) step();
    check("rst_addr", addr, 0);
    check("rst_rd", rd, 0);
    check("rst_bad", bad, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_first_err_addr", first_err_addr, 0);
    rst_n = 1'b1;
    step();
    mon_en = 1'b1;

    // clean pass with fixed ack/rdy delays
    clear_plan();
    run_pass();

    // one corrupted word at addr 2, plus a start that must be ignored
    clear_plan();
    p_kind[2]  = 1;
    p_start[4] = 1;
    run_pass();
    check("corrupt_first_addr", first_err_addr, 2);
    check("corrupt_err_cnt", err_cnt, 1);

    // clear, then a read that never returns data at addr 1
    clear_plan();
    p_clr[0]  = 1;
    p_kind[1] = 2;
    run_pass();
    check("timeout_err_cnt", err_cnt, 1);
    check("timeout_first_addr", first_err_addr, 1);

    // clear while busy, then same-cycle ack+rdy words
    clear_plan();
    p_clr[0]  = 1;
    p_same[3] = 1; p_ack[3] = 0;
    p_same[5] = 1;
    run_pass();
    check("clr_bad", bad, 0);
    check("clr_err_cnt", err_cnt, 0);

    // saturation: 38 passes of corrupted words
    for (int n = 0; n < 38; n++) begin
      rand_plan(1'b1);
      for (int i = 0; i < NW; i++) p_start[i] = 0;
      run_pass();
    end
    check("sat_err_cnt", err_cnt, 8'hFF);

    // clr coincident with the mismatch at addr 7
    rand_plan(1'b1);
    p_clr[7] = 2;
    run_pass();
    check("clr_err_cnt_coincident", err_cnt, 1);
    check("clr_first_addr_coincident", first_err_addr, 7);

    // random passes
    repeat (4) begin
      rand_plan(1'b0);
      run_pass();
    end

    // rdy/ack while DONE are ignored
    rdy = 1'b1; ack = 1'b1; din = DW'($urandom);
    step();
    rdy = 1'b0; ack = 1'b0;
    step();
    check("done_ignore_err_cnt", err_cnt, m_cnt);
    check("done_ignore_bad", bad, m_bad);
    check("done_ignore_done", done, 1);
    check("done_ignore_rd", rd, 0);

    // reset in the middle of a WAIT
    mon_en = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_rd(20, ok);
    ack = 1'b1;
    step();
    ack = 1'b0;
    step();
    step();
    check("wait_rd_low", rd, 0);
    check("wait_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("async_rd", rd, 0);
    check("async_busy", busy, 0);
    check("async_done", done, 0);
    check("async_bad", bad, 0);
    check("async_addr", addr, 0);
    step();
    rst_n = 1'b1;
    step();
    rdy = 1'b1; din = 16'h1234;
    step();
    rdy = 1'b0;
    step();
    step();
    check("late_rdy_err_cnt", err_cnt, 0);
    check("late_rdy_bad", bad, 0);
    check("late_rdy_busy", busy, 0);
    check("late_rdy_rd", rd, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
